// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings for the sized data memory.
//   SZ_BYTE/SZ_HALF/SZ_WORD : Size_i encodings (2'b11 is illegal)
//   state_t                 : controller states
//   lane_mask()             : byte-lane enables for a given size and addr[1:0]
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_ACCESS, ST_RESP} state_t;

    // Halves always start on an even lane; the illegal size selects no lanes.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
        return size == SZ_BYTE ? 4'b0001 << lo :
               size == SZ_HALF ? 4'b0011 << {lo[1], 1'b0} :
               size == SZ_WORD ? 4'b1111 : 4'b0000;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: store-lane replication/masking and load shift/extension.
//   size, lo    : access size and byte offset addr[1:0]
//   is_unsigned : zero-extend loads when 1, sign-extend when 0
//   store_data  : right-aligned store data
//   mem_word    : addressed memory word
//   store_word  : store data replicated onto every candidate lane
//   store_mask  : lanes to write
//   load_data   : extended load result
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lo,
    input  logic        is_unsigned,
    input  logic [31:0] store_data,
    input  logic [31:0] mem_word,
    output logic [31:0] store_word,
    output logic [3:0]  store_mask,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        store_word = size == SZ_BYTE ? {4{store_data[7:0]}} :
                     size == SZ_HALF ? {2{store_data[15:0]}} : store_data;
        store_mask = lane_mask(size, lo);
        byte_sel   = mem_word[8*lo +: 8];
        half_sel   = lo[1] ? mem_word[31:16] : mem_word[15:0];
        load_data  = size == SZ_BYTE ? {{24{byte_sel[7] & ~is_unsigned}}, byte_sel} :
                     size == SZ_HALF ? {{16{half_sel[15] & ~is_unsigned}}, half_sel} : mem_word;
    end

endmodule

// File: rtl/data_memory_sized.sv
// data_memory_sized: byte-addressed little-endian data memory with sized access,
// request/valid handshake, configurable wait states and post-reset zeroing sweep.
//   Clock_i, Reset_n_i        : clock, asynchronous active-low reset
//   Req_i                     : request strobe, taken while Ready_o=1
//   MemWrite_i, MemRead_i     : access direction (exactly one must be set)
//   Size_i, Unsigned_i        : access size, load extension select
//   addr_i, data_i            : byte address, right-aligned store data
//   Ready_o, Valid_o          : can accept request, one-cycle response strobe
//   data_o, Error_o           : load result, request rejected (held until next response)
//   Busy_o                    : zeroing sweep in progress
module data_memory_sized
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024,
    parameter int WAIT_STATES = 1,
    parameter bit INIT_ZERO   = 1'b1
)(
    input  logic        Clock_i,
    input  logic        Reset_n_i,
    input  logic        Req_i,
    input  logic        MemWrite_i,
    input  logic        MemRead_i,
    input  logic [1:0]  Size_i,
    input  logic        Unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic        Ready_o,
    output logic        Valid_o,
    output logic [31:0] data_o,
    output logic        Error_o,
    output logic        Busy_o
);

    localparam int WORDS = DEPTH_BYTES / 4;
    localparam int AW    = $clog2(DEPTH_BYTES);
    localparam int IW    = AW - 2;
    localparam logic [IW-1:0] LAST   = IW'(WORDS - 1);
    localparam state_t        RST_ST = INIT_ZERO ? ST_INIT : ST_IDLE;

    state_t        state, state_nx;
    logic [2:0]    wait_cnt;
    logic [IW-1:0] init_idx;
    logic          req_we, req_re, req_uns;
    logic [1:0]    req_size;
    logic [31:0]   req_addr, req_data;
    logic [31:0]   mem [WORDS];
    logic          accept, done, bad;
    logic [31:0]   store_word, load_data;
    logic [3:0]    store_mask;
    logic [IW-1:0] word_idx;

    assign word_idx = req_addr[AW-1:2];
    assign accept   = Req_i && Ready_o;
    assign done     = state == ST_ACCESS && wait_cnt == 3'd0;
    // Range check uses all 32 address bits so high addresses never alias.
    assign bad      = req_size == 2'b11 || req_we == req_re ||
                      (req_size == SZ_HALF && req_addr[0]) ||
                      (req_size == SZ_WORD && req_addr[1:0] != 2'b00) ||
                      req_addr >= 32'(DEPTH_BYTES);

    dmem_lane_align u_align (
        .size        (req_size),
        .lo          (req_addr[1:0]),
        .is_unsigned (req_uns),
        .store_data  (req_data),
        .mem_word    (mem[word_idx]),
        .store_word  (store_word),
        .store_mask  (store_mask),
        .load_data   (load_data)
    );

    always_ff @(posedge Clock_i or negedge Reset_n_i)
        if (!Reset_n_i)
            state <= RST_ST;
        else
            state <= state_nx;

    always_comb begin
        Ready_o  = state == ST_IDLE || state == ST_RESP;
        Valid_o  = state == ST_RESP;
        Busy_o   = state == ST_INIT;
        state_nx = state == ST_INIT ? (init_idx == LAST ? ST_IDLE : ST_INIT) :
                   accept           ? ST_ACCESS :
                   done             ? ST_RESP :
                   state == ST_RESP ? ST_IDLE : state;
    end

    always_ff @(posedge Clock_i or negedge Reset_n_i)
        if (!Reset_n_i) begin
            wait_cnt <= 3'd0;
            init_idx <= '0;
            data_o   <= '0;
            Error_o  <= 1'b0;
            req_we   <= 1'b0;
            req_re   <= 1'b0;
            req_uns  <= 1'b0;
            req_size <= 2'b00;
            req_addr <= '0;
            req_data <= '0;
        end else begin
            if (state == ST_INIT)
                init_idx <= init_idx + IW'(1);
            if (accept) begin
                req_we   <= MemWrite_i;
                req_re   <= MemRead_i;
                req_uns  <= Unsigned_i;
                req_size <= Size_i;
                req_addr <= addr_i;
                req_data <= data_i;
                wait_cnt <= 3'(WAIT_STATES);
            end else if (state == ST_ACCESS && wait_cnt != 3'd0)
                wait_cnt <= wait_cnt - 3'd1;
            if (done) begin
                Error_o <= bad;
                data_o  <= bad ? '0 : req_re ? load_data : data_o;
            end
        end

    // Storage has no reset; a reset during ACCESS leaves state outside ACCESS,
    // so a pending write simply never commits.
    always_ff @(posedge Clock_i)
        if (state == ST_INIT)
            mem[init_idx] <= '0;
        else if (done && req_we && !bad)
            for (int i = 0; i < 4; i++)
                if (store_mask[i])
                    mem[word_idx][8*i +: 8] <= store_word[8*i +: 8];

endmodule

// File: tb/tb_data_memory_sized.sv
// tb_data_memory_sized: directed bench with a byte-array reference model.
module tb_data_memory_sized;

    localparam int DEPTH = 64;
    localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, X = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst_n, req;
    logic        mw, mr, uns;
    logic [1:0]  sz;
    logic [31:0] addr, wdata;
    logic [1:0]  rdy, vld, err, busy;
    logic [31:0] dout [2];
    int vectors = 0, miscompares = 0;

    // dut0: no wait states, no sweep; dut1: one wait state, zeroing sweep.
    data_memory_sized #(.DEPTH_BYTES(DEPTH), .WAIT_STATES(0), .INIT_ZERO(0)) u_dut0 (
        .Clock_i(clk), .Reset_n_i(rst_n[0]), .Req_i(req[0]), .MemWrite_i(mw), .MemRead_i(mr),
        .Size_i(sz), .Unsigned_i(uns), .addr_i(addr), .data_i(wdata), .Ready_o(rdy[0]),
        .Valid_o(vld[0]), .data_o(dout[0]), .Error_o(err[0]), .Busy_o(busy[0]));

    data_memory_sized #(.DEPTH_BYTES(DEPTH), .WAIT_STATES(1), .INIT_ZERO(1)) u_dut1 (
        .Clock_i(clk), .Reset_n_i(rst_n[1]), .Req_i(req[1]), .MemWrite_i(mw), .MemRead_i(mr),
        .Size_i(sz), .Unsigned_i(uns), .addr_i(addr), .data_i(wdata), .Ready_o(rdy[1]),
        .Valid_o(vld[1]), .data_o(dout[1]), .Error_o(err[1]), .Busy_o(busy[1]));

    // Reference model: instance k has k wait states; instance 1 sweeps after reset.
    logic [7:0]  mm [2][DEPTH];
    int          init_left [2], pend [2];
    logic        p_we [2], p_re [2], p_uns [2];
    logic [1:0]  p_sz [2];
    logic [31:0] p_addr [2], p_data [2];
    logic        e_vld [2], e_err [2];
    logic [31:0] e_dat [2];

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d: got %h, expected %h at %0t", name, k, act, exp, $time);
        end
    endtask

    task automatic m_reset(input int k);
        init_left[k] = (k == 1) ? DEPTH / 4 : 0;
        pend[k]  = 0;
        e_vld[k] = 1'b0;
        e_err[k] = 1'b0;
        e_dat[k] = '0;
    endtask

    task automatic m_commit(input int k);
        int n = p_sz[k] == B ? 1 : p_sz[k] == H ? 2 : 4;
        logic [31:0] v = '0;
        bit bad = p_sz[k] == X || p_we[k] == p_re[k] || (p_addr[k] % 32'(n)) != 0 ||
                  p_addr[k] >= 32'(DEPTH);
        e_err[k] = bad;
        if (bad)
            e_dat[k] = '0;
        else if (p_we[k])
            for (int i = 0; i < n; i++) mm[k][int'(p_addr[k]) + i] = p_data[k][8*i +: 8];
        else begin
            for (int i = 0; i < n; i++) v |= 32'(mm[k][int'(p_addr[k]) + i]) << (8*i);
            if (n < 4 && !p_uns[k] && v[8*n-1]) v |= 32'hFFFF_FFFF << (8*n);
            e_dat[k] = v;
        end
    endtask

    task automatic m_step(input int k);
        bit was_ready = init_left[k] == 0 && pend[k] == 0;
        e_vld[k] = pend[k] == 1;
        if (pend[k] > 0) pend[k]--;
        if (e_vld[k]) m_commit(k);
        if (init_left[k] > 0) begin
            init_left[k]--;
            if (init_left[k] == 0)
                for (int i = 0; i < DEPTH; i++) mm[k][i] = 8'h00;
        end else if (was_ready && req[k]) begin
            pend[k]   = k + 1;
            p_we[k]   = mw;
            p_re[k]   = mr;
            p_uns[k]  = uns;
            p_sz[k]   = sz;
            p_addr[k] = addr;
            p_data[k] = wdata;
        end
    endtask

    always @(posedge clk or negedge rst_n[0])
        if (!rst_n[0]) m_reset(0); else m_step(0);

    always @(posedge clk or negedge rst_n[1])
        if (!rst_n[1]) m_reset(1); else m_step(1);

    always @(negedge clk)
        for (int k = 0; k < 2; k++) begin
            chk("ready", k, 32'(rdy[k]), 32'(init_left[k] == 0 && pend[k] == 0));
            chk("busy", k, 32'(busy[k]), 32'(init_left[k] > 0));
            chk("valid", k, 32'(vld[k]), 32'(e_vld[k]));
            chk("error", k, 32'(err[k]), 32'(e_err[k]));
            chk("data", k, dout[k], e_dat[k]);
        end

    // One request with literal expectations on latency, error and (optionally) data.
    task automatic xact(input int k, input bit w, input bit r, input logic [1:0] s, input bit u,
                        input logic [31:0] a, input logic [31:0] d, input bit exp_err,
                        input bit chk_dat, input logic [31:0] exp_dat);
        int n = 0;
        while (!rdy[k] && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        mw = w; mr = r; sz = s; uns = u; addr = a; wdata = d; req[k] = 1'b1;
        @(posedge clk); #1;
        req[k] = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!vld[k] && n < 20);
        chk("latency", k, 32'(n), 32'(k + 2));
        chk("lit_error", k, 32'(err[k]), 32'(exp_err));
        if (chk_dat) chk("lit_data", k, dout[k], exp_dat);
    endtask

    task automatic wr(input int k, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
        xact(k, 1'b1, 1'b0, s, 1'b0, a, d, 1'b0, 1'b0, '0);
    endtask

    task automatic rd(input int k, input logic [1:0] s, input bit u, input logic [31:0] a,
                      input logic [31:0] exp);
        xact(k, 1'b0, 1'b1, s, u, a, '0, 1'b0, 1'b1, exp);
    endtask

    task automatic bad(input int k, input bit w, input bit r, input logic [1:0] s, input logic [31:0] a);
        xact(k, w, r, s, 1'b0, a, 32'hDEAD_BEEF, 1'b1, 1'b1, '0);
    endtask

    initial begin
        int n;
        rst_n = 2'b00; req = 2'b00; mw = 0; mr = 0; sz = 0; uns = 0; addr = 0; wdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 1, 32'(busy[1]), 1);
        chk("rst_ready", 1, 32'(rdy[1]), 0);
        chk("rst_ready", 0, 32'(rdy[0]), 1);
        chk("rst_valid", 1, 32'(vld[1]), 0);
        @(posedge clk); #1;
        rst_n = 2'b11;
        n = 0;
        @(negedge clk);
        while (busy[1] && n < 100) begin n++; @(negedge clk); end
        chk("init_cycles", 1, 32'(n), 16);
        chk("ready_after_init", 1, 32'(rdy[1]), 1);

        rd(1, W, 0, 32'h3C, 32'h0000_0000);
        wr(1, W, 32'h10, 32'h8081_7F01);
        rd(1, B, 0, 32'h10, 32'h0000_0001);
        rd(1, B, 0, 32'h11, 32'h0000_007F);
        rd(1, B, 0, 32'h13, 32'hFFFF_FF80);
        rd(1, B, 1, 32'h12, 32'h0000_0081);
        wr(1, W, 32'h20, 32'h1122_3344);
        wr(1, H, 32'h22, 32'h0000_BEEF);
        rd(1, W, 0, 32'h20, 32'hBEEF_3344);
        rd(1, H, 0, 32'h22, 32'hFFFF_BEEF);
        bad(1, 0, 1, H, 32'h21);
        bad(1, 1, 0, W, 32'h06);
        bad(1, 0, 1, X, 32'h00);
        bad(1, 1, 1, W, 32'h20);
        bad(1, 0, 0, W, 32'h20);
        bad(1, 0, 1, W, 32'h40);
        rd(1, W, 0, 32'h20, 32'hBEEF_3344);
        rd(1, W, 0, 32'h04, 32'h0000_0000);
        rd(1, W, 0, 32'h00, 32'h0000_0000);

        wr(0, W, 32'h08, 32'hCAFE_F00D);
        wr(0, W, 32'h00, 32'hA5A5_5A5A);
        rd(0, H, 1, 32'h0A, 32'h0000_CAFE);
        rd(0, H, 0, 32'h0A, 32'hFFFF_CAFE);

        @(posedge clk); #1;
        mw = 0; mr = 1; sz = W; uns = 0; addr = 32'h00; req[0] = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin @(negedge clk); if (vld[0]) n++; end
        @(posedge clk); #1;
        req[0] = 1'b0;
        chk("b2b_valids", 0, 32'(n), 3);
        chk("b2b_data", 0, dout[0], 32'hA5A5_5A5A);
        repeat (2) @(negedge clk);

        @(posedge clk); #1;
        mw = 1; mr = 0; sz = W; addr = 32'h08; wdata = 32'h1234_5678; req[0] = 1'b1;
        @(posedge clk); #1;
        req[0] = 1'b0;
        rst_n[0] = 1'b0;
        #1 chk("valid_in_reset", 0, 32'(vld[0]), 0);
        @(negedge clk);
        chk("valid_in_reset", 0, 32'(vld[0]), 0);
        @(posedge clk); #1;
        rst_n[0] = 1'b1;
        rd(0, W, 0, 32'h08, 32'hCAFE_F00D);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
        $fatal(1);
    end

endmodule
